// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// ctrl_t carries every control field produced per state, before ready/reset gating.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ORI_EX  = 4'd10,
        S_IMM_WB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // branch: pc_en follows zero_i; op_chk: state where the opcode is validated
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       imm_ext_type;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       op_chk;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: op_legal = 1'b1;
            default:                                               op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath/memory (slave).
// Carries the IR opcode, ALU zero flag and memory ready into the FSM, and all enables/selects out.
interface mc_if;
    logic [5:0] op_i6;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o;
    logic       iord_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       pc_en_o;
    logic [1:0] pc_src_o2;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o2;
    logic [1:0] alu_op_o2;
    logic       imm_ext_type_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       illegal_o;

    modport master (
        input  op_i6, zero_i, mem_ready_i,
        output mem_req_o, iord_o, mem_write_o, ir_write_o, pc_en_o, pc_src_o2,
               alu_src_a_o, alu_src_b_o2, alu_op_o2, imm_ext_type_o, reg_dst_o,
               mem_to_reg_o, reg_write_o, illegal_o
    );

    modport slave (
        output op_i6, zero_i, mem_ready_i,
        input  mem_req_o, iord_o, mem_write_o, ir_write_o, pc_en_o, pc_src_o2,
               alu_src_a_o, alu_src_b_o2, alu_op_o2, imm_ext_type_o, reg_dst_o,
               mem_to_reg_o, reg_write_o, illegal_o
    );
endinterface

// File: rtl/mc_state_dec.sv
// Moore output decode: maps the FSM state to its raw control word.
// Purely combinational, zero latency; no handshake of its own.
module mc_state_dec
    import mc_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_en     = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SL2;
                ctrl_o.op_chk    = 1'b1;
            end
            S_MEM_ADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_R_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = PC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_ORI_EX: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_IMM;
                ctrl_o.alu_op       = ALU_OR;
                ctrl_o.imm_ext_type = 1'b1;
            end
            S_IMM_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src = PC_JUMP;
                ctrl_o.pc_en  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: lw 5 cycles; sw/R/addi/ori 4; beq/j 3 (zero-wait memory).
// Stalls in FETCH, MEM_RD and MEM_WR while mem_ready_i is low, holding every output stable.
module mc_controller
    import mc_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    mc_if.master bus
);

    state_t state_q, state_d;
    state_t dec_state;
    ctrl_t  ctrl;
    logic   ready_ok;
    logic   run;

    // Reset presents FETCH selects so the datapath sees a clean fetch setup
    assign dec_state = reset_i ? S_FETCH : state_q;

    mc_state_dec u_state_dec (
        .state_i (dec_state),
        .ctrl_o  (ctrl)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (bus.mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op_i6)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: state_d = (bus.op_i6 == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (bus.mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WR:  if (bus.mem_ready_i) state_d = S_FETCH;
            S_R_EX:    state_d = S_ALU_WB;
            S_ADDI_EX: state_d = S_IMM_WB;
            S_ORI_EX:  state_d = S_IMM_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Ready only matters for states that are actually requesting memory
    assign ready_ok = ~ctrl.mem_req | bus.mem_ready_i;
    assign run      = ~reset_i;

    assign bus.mem_req_o      = run & ctrl.mem_req;
    assign bus.iord_o         = ctrl.iord;
    assign bus.mem_write_o    = run & ctrl.mem_write;
    assign bus.ir_write_o     = run & ctrl.ir_write & ready_ok;
    assign bus.pc_en_o        = run & ((ctrl.pc_en & ready_ok) | (ctrl.branch & bus.zero_i));
    assign bus.pc_src_o2      = ctrl.pc_src;
    assign bus.alu_src_a_o    = ctrl.alu_src_a;
    assign bus.alu_src_b_o2   = ctrl.alu_src_b;
    assign bus.alu_op_o2      = ctrl.alu_op;
    assign bus.imm_ext_type_o = ctrl.imm_ext_type;
    assign bus.reg_dst_o      = ctrl.reg_dst;
    assign bus.mem_to_reg_o   = ctrl.mem_to_reg;
    assign bus.reg_write_o    = run & ctrl.reg_write;
    assign bus.illegal_o      = run & ctrl.op_chk & ~op_legal(bus.op_i6);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each scenario pushes per-cycle expectations, then pops and compares.
module tb_mc_controller;
    import mc_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_a;
        logic [1:0] alu_b;
        logic [1:0] alu_op;
        logic       imm_ext;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } out_t;

    typedef struct {
        state_t     st;
        logic       rs;
        logic       rd;
        logic       zr;
        logic [5:0] op;
    } row_t;

    typedef struct {
        state_t st;
        out_t   o;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_if bus();

    mc_controller dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.master)
    );

    item_t sb[$];
    int    n_vec = 0;
    int    n_bad = 0;

    // Reference outputs written straight from the state table
    function automatic out_t model(state_t s, logic r, logic rdy, logic z, logic [5:0] op);
        out_t o;
        o = '0;
        if (r) begin
            o.alu_b = 2'b01;
            return o;
        end
        case (s)
            S_FETCH:   begin o.mem_req = 1; o.alu_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
            S_DECODE:  begin
                o.alu_b   = 2'b11;
                o.illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                         6'b001000, 6'b001101, 6'b000010});
            end
            S_MEM_ADR: begin o.alu_a = 1; o.alu_b = 2'b10; end
            S_MEM_RD:  begin o.mem_req = 1; o.iord = 1; end
            S_MEM_WB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            S_MEM_WR:  begin o.mem_req = 1; o.iord = 1; o.mem_write = 1; end
            S_R_EX:    begin o.alu_a = 1; o.alu_op = 2'b10; end
            S_ALU_WB:  begin o.reg_write = 1; o.reg_dst = 1; end
            S_BRANCH:  begin o.alu_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; end
            S_ADDI_EX: begin o.alu_a = 1; o.alu_b = 2'b10; end
            S_ORI_EX:  begin o.alu_a = 1; o.alu_b = 2'b10; o.alu_op = 2'b11; o.imm_ext = 1; end
            S_IMM_WB:  begin o.reg_write = 1; end
            S_JUMP:    begin o.pc_src = 2'b10; o.pc_en = 1; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.mem_req    = bus.mem_req_o;
        o.iord       = bus.iord_o;
        o.mem_write  = bus.mem_write_o;
        o.ir_write   = bus.ir_write_o;
        o.pc_en      = bus.pc_en_o;
        o.pc_src     = bus.pc_src_o2;
        o.alu_a      = bus.alu_src_a_o;
        o.alu_b      = bus.alu_src_b_o2;
        o.alu_op     = bus.alu_op_o2;
        o.imm_ext    = bus.imm_ext_type_o;
        o.reg_dst    = bus.reg_dst_o;
        o.mem_to_reg = bus.mem_to_reg_o;
        o.reg_write  = bus.reg_write_o;
        o.illegal    = bus.illegal_o;
        return o;
    endfunction

    task automatic drive(input row_t r);
        rst             = r.rs;
        bus.mem_ready_i = r.rd;
        bus.zero_i      = r.zr;
        bus.op_i6       = r.op;
        sb.push_back('{r.st, model(r.st, r.rs, r.rd, r.zr, r.op)});
    endtask

    task automatic test_reset();
        row_t  t[7] = '{
            '{S_FETCH,  1'b1, 1'b1, 1'b0, 6'b000000},
            '{S_FETCH,  1'b1, 1'b1, 1'b1, 6'b000000},
            '{S_FETCH,  1'b1, 1'b1, 1'b0, 6'b000000},
            '{S_FETCH,  1'b0, 1'b1, 1'b0, 6'b000000},
            '{S_DECODE, 1'b0, 1'b1, 1'b0, 6'b000000},
            '{S_R_EX,   1'b0, 1'b1, 1'b0, 6'b000000},
            '{S_ALU_WB, 1'b0, 1'b1, 1'b0, 6'b000000}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 7; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL reset[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL reset[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        row_t  t[5] = '{
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_LW},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_ADR, 1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_RD,  1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_WB,  1'b0, 1'b1, 1'b0, OP_LW}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 5; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL lw[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL lw[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        row_t  t[7] = '{
            '{S_FETCH,   1'b0, 1'b0, 1'b0, OP_SW},
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_SW},
            '{S_DECODE,  1'b0, 1'b0, 1'b0, OP_SW},
            '{S_MEM_ADR, 1'b0, 1'b0, 1'b0, OP_SW},
            '{S_MEM_WR,  1'b0, 1'b0, 1'b0, OP_SW},
            '{S_MEM_WR,  1'b0, 1'b0, 1'b0, OP_SW},
            '{S_MEM_WR,  1'b0, 1'b1, 1'b0, OP_SW}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 7; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL sw_stall[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL sw_stall[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        row_t  t[6] = '{
            '{S_FETCH,  1'b0, 1'b1, 1'b0, OP_BEQ},
            '{S_DECODE, 1'b0, 1'b1, 1'b0, OP_BEQ},
            '{S_BRANCH, 1'b0, 1'b0, 1'b1, OP_BEQ},
            '{S_FETCH,  1'b0, 1'b1, 1'b1, OP_BEQ},
            '{S_DECODE, 1'b0, 1'b1, 1'b1, OP_BEQ},
            '{S_BRANCH, 1'b0, 1'b1, 1'b0, OP_BEQ}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 6; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL beq[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL beq[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm_jump();
        row_t  t[11] = '{
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_ORI},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_ORI},
            '{S_ORI_EX,  1'b0, 1'b1, 1'b0, OP_ORI},
            '{S_IMM_WB,  1'b0, 1'b1, 1'b0, OP_ORI},
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_ADDI},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_ADDI},
            '{S_ADDI_EX, 1'b0, 1'b1, 1'b0, OP_ADDI},
            '{S_IMM_WB,  1'b0, 1'b1, 1'b0, OP_ADDI},
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_J},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_J},
            '{S_JUMP,    1'b0, 1'b0, 1'b0, OP_J}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 11; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL imm_jump[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL imm_jump[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        row_t  t[3] = '{
            '{S_FETCH,  1'b0, 1'b1, 1'b0, 6'b111111},
            '{S_DECODE, 1'b0, 1'b1, 1'b0, 6'b111111},
            '{S_FETCH,  1'b0, 1'b0, 1'b0, 6'b111111}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 3; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL illegal[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL illegal[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t  t[10] = '{
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_LW},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_ADR, 1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_RD,  1'b0, 1'b0, 1'b0, OP_LW},
            '{S_MEM_RD,  1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_WB,  1'b0, 1'b0, 1'b0, OP_LW},
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_RTYPE},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_RTYPE},
            '{S_R_EX,    1'b0, 1'b1, 1'b1, OP_RTYPE},
            '{S_ALU_WB,  1'b0, 1'b1, 1'b0, OP_RTYPE}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 10; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL b2b[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL b2b[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        row_t  t[7] = '{
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_LW},
            '{S_DECODE,  1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_ADR, 1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_RD,  1'b0, 1'b1, 1'b0, OP_LW},
            '{S_MEM_WB,  1'b1, 1'b1, 1'b0, OP_LW},
            '{S_FETCH,   1'b0, 1'b0, 1'b0, OP_LW},
            '{S_FETCH,   1'b0, 1'b1, 1'b0, OP_LW}};
        item_t e;
        out_t  g;
        for (int i = 0; i < 7; i++) begin
            drive(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            n_vec++;
            if (g !== e.o) begin n_bad++; $display("FAIL reset_mid[%0d] outputs got=%h want=%h", i, g, e.o); end
            n_vec++;
            if (dut.state_q !== e.st) begin n_bad++; $display("FAIL reset_mid[%0d] state got=%0d want=%0d", i, dut.state_q, e.st); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.mem_ready_i = 1'b1;
        bus.zero_i      = 1'b0;
        bus.op_i6       = 6'b000000;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_imm_jump();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
